// File: rtl/svc_axil_pkg.sv
// Shared AXI-Lite constants for the svc_axil router family.
// The response codes and the bus-error data word are common to the read and write routers.
package svc_axil_pkg;

  typedef logic [1:0] axil_resp_t;

  localparam axil_resp_t  RESP_OKAY    = 2'b00;
  localparam axil_resp_t  RESP_SLVERR  = 2'b10;
  localparam axil_resp_t  RESP_DECERR  = 2'b11;
  localparam logic [31:0] BUS_ERR_DATA = 32'hADD1EBAD;

  // Saturating 16-bit increment, used by the optional error counters.
  function automatic logic [15:0] satInc16(input logic [15:0] value);
    return (value == 16'hFFFF) ? value : value + 16'd1;
  endfunction

endpackage

// File: rtl/svc_axil_addr_dec.sv
// Combinational base/mask address decoder.
// The lowest matching subordinate index wins; no match selects index NUM_S and raises err_o.
// The forwarded address has the decode bits cleared.
module svc_axil_addr_dec #(
  parameter int                  NUM_S  = 2,
  parameter int                  AW     = 32,
  parameter logic [NUM_S*AW-1:0] S_BASE = {32'h4000_0000, 32'h0000_0000},
  parameter logic [NUM_S*AW-1:0] S_MASK = {32'hC000_0000, 32'hC000_0000}
) (
  input  logic [AW-1:0]                addr_i,
  output logic [$clog2(NUM_S+1)-1:0]   sel_o,
  output logic                         err_o,
  output logic [AW-1:0]                addr_o
);

  localparam int SW = $clog2(NUM_S + 1);

  // Scan from the highest index down so the lowest matching window has the final say.
  always_comb begin
    sel_o  = SW'(NUM_S);
    err_o  = 1'b1;
    addr_o = addr_i;
    for (int i = NUM_S - 1; i >= 0; i--) begin
      if ((addr_i & S_MASK[i*AW +: AW]) == S_BASE[i*AW +: AW]) begin
        sel_o  = SW'(i);
        err_o  = 1'b0;
        addr_o = addr_i & ~S_MASK[i*AW +: AW];
      end
    end
  end

endmodule

// File: rtl/svc_skidbuf.sv
// Two-entry valid/ready skid buffer.
// OPT_OUTREG=0: combinational pass-through with a single spill slot (in_ready only drops when full).
// OPT_OUTREG=1: registered output plus spill slot, one cycle from input handshake to out_valid.
module svc_skidbuf #(
  parameter int WIDTH      = 32,
  parameter bit OPT_OUTREG = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_data_o
);

  logic             full_q;
  logic [WIDTH-1:0] buf_q;

  assign in_ready_o = !full_q;

  if (OPT_OUTREG) begin : g_outreg
    logic             outValid_q;
    logic [WIDTH-1:0] outData_q;

    // Output register refills from the spill slot first, otherwise from the input.
    always_ff @(posedge clk) begin
      if (rst) begin
        full_q     <= 1'b0;
        outValid_q <= 1'b0;
      end else if (!outValid_q || out_ready_i) begin
        outValid_q <= full_q || in_valid_i;
        full_q     <= 1'b0;
      end else if (in_valid_i && !full_q) begin
        full_q <= 1'b1;
      end
    end

    // Data path registers carry no reset; the valid flags qualify them.
    always_ff @(posedge clk) begin
      if (!outValid_q || out_ready_i) begin
        outData_q <= full_q ? buf_q : in_data_i;
      end
      if (in_valid_i && !full_q && outValid_q && !out_ready_i) begin
        buf_q <= in_data_i;
      end
    end

    assign out_valid_o = outValid_q;
    assign out_data_o  = outData_q;
  end else begin : g_passthru
    // Spill slot fills when the consumer stalls a valid input and drains when it accepts.
    always_ff @(posedge clk) begin
      if (rst) begin
        full_q <= 1'b0;
      end else if (out_ready_i) begin
        full_q <= 1'b0;
      end else if (in_valid_i && !full_q) begin
        full_q <= 1'b1;
      end
    end

    // Capture the stalled input word into the spill slot.
    always_ff @(posedge clk) begin
      if (in_valid_i && !full_q && !out_ready_i) begin
        buf_q <= in_data_i;
      end
    end

    assign out_valid_o = full_q || in_valid_i;
    assign out_data_o  = full_q ? buf_q : in_data_i;
  end

endmodule

// File: rtl/svc_axil_router_rd_pipe.sv
// Pipelined AXI-Lite read router, one manager to NUM_S subordinates.
// Reads to the current subordinate issue back to back up to MAX_OUTSTANDING; switching target
// waits until every outstanding read has returned, so responses stay in order without reordering.
// Unmapped reads complete in order with DECERR and BUS_ERR_DATA.
// Optional: define SVC_AXIL_ROUTER_RD_PIPE_ERRCNT_EN to add a saturating 16-bit decerr_count output.
module svc_axil_router_rd_pipe
  import svc_axil_pkg::*;
#(
  parameter int                  AW              = 32,
  parameter int                  DW              = 32,
  parameter int                  NUM_S           = 2,
  parameter logic [NUM_S*AW-1:0] S_BASE          = {32'h4000_0000, 32'h0000_0000},
  parameter logic [NUM_S*AW-1:0] S_MASK          = {32'hC000_0000, 32'hC000_0000},
  parameter int                  MAX_OUTSTANDING = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                s_axil_arvalid,
  input  logic [AW-1:0]       s_axil_araddr,
  output logic                s_axil_arready,
  output logic                s_axil_rvalid,
  output logic [DW-1:0]       s_axil_rdata,
  output logic [1:0]          s_axil_rresp,
  input  logic                s_axil_rready,
  output logic [NUM_S-1:0]    m_axil_arvalid,
  output logic [NUM_S*AW-1:0] m_axil_araddr,
  input  logic [NUM_S-1:0]    m_axil_arready,
  input  logic [NUM_S-1:0]    m_axil_rvalid,
  input  logic [NUM_S*DW-1:0] m_axil_rdata,
  input  logic [NUM_S*2-1:0]  m_axil_rresp,
  output logic [NUM_S-1:0]    m_axil_rready
`ifdef SVC_AXIL_ROUTER_RD_PIPE_ERRCNT_EN
  ,
  output logic [15:0]         decerr_count
`endif
);

  localparam int             SW      = $clog2(NUM_S + 1);
  localparam int             CW      = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [SW-1:0]  ERR_SEL = SW'(NUM_S);

  logic                       arSkidValid;
  logic [AW-1:0]              arSkidAddr;
  logic                       arIssueReady;
  logic                       accept;
  logic [SW-1:0]              decSel;
  logic                       decErr;
  logic [AW-1:0]              decAddr;
  logic                       targetFree;
  logic                       slotOk;

  logic [CW-1:0]              cnt_q, cnt_d;
  logic [SW-1:0]              curSel_q, curSel_d;
  logic [NUM_S-1:0]           arValid_q, arValid_d;
  logic [NUM_S-1:0][AW-1:0]   arAddr_q, arAddr_d;

  logic                       rspValid;
  logic                       rspReady;
  logic                       rspAccept;
  logic [DW-1:0]              rspData;
  logic [1:0]                 rspResp;
  logic [DW+1:0]              rOutData;

  svc_skidbuf #(
    .WIDTH      (AW),
    .OPT_OUTREG (1'b0)
  ) u_arSkid (
    .clk         (clk),
    .rst         (rst),
    .in_valid_i  (s_axil_arvalid),
    .in_ready_o  (s_axil_arready),
    .in_data_i   (s_axil_araddr),
    .out_valid_o (arSkidValid),
    .out_ready_i (arIssueReady),
    .out_data_o  (arSkidAddr)
  );

  svc_axil_addr_dec #(
    .NUM_S  (NUM_S),
    .AW     (AW),
    .S_BASE (S_BASE),
    .S_MASK (S_MASK)
  ) u_addrDec (
    .addr_i (arSkidAddr),
    .sel_o  (decSel),
    .err_o  (decErr),
    .addr_o (decAddr)
  );

  // Issue gate: same target with headroom (or an idle router) and a free address register.
  always_comb begin
    targetFree = 1'b1;
    for (int i = 0; i < NUM_S; i++) begin
      if ((decSel == SW'(i)) && arValid_q[i] && !m_axil_arready[i]) begin
        targetFree = 1'b0;
      end
    end
    slotOk       = (cnt_q == '0) ||
                   ((decSel == curSel_q) && (cnt_q < CW'(MAX_OUTSTANDING)));
    arIssueReady = slotOk && targetFree;
  end

  assign accept = arSkidValid && arIssueReady;

  // Response source: the selected subordinate, or the internal DECERR generator; only it sees rready.
  always_comb begin
    rspValid      = 1'b0;
    rspData       = DW'(BUS_ERR_DATA);
    rspResp       = RESP_DECERR;
    m_axil_rready = '0;
    if (cnt_q != '0) begin
      if (curSel_q == ERR_SEL) begin
        rspValid = 1'b1;
      end else begin
        for (int i = 0; i < NUM_S; i++) begin
          if (curSel_q == SW'(i)) begin
            rspValid         = m_axil_rvalid[i];
            rspData          = m_axil_rdata[i*DW +: DW];
            rspResp          = m_axil_rresp[i*2 +: 2];
            m_axil_rready[i] = rspReady;
          end
        end
      end
    end
  end

  assign rspAccept = rspValid && rspReady;

  // Next-state for the outstanding count, current target and per-subordinate AR registers.
  always_comb begin
    cnt_d     = cnt_q;
    curSel_d  = accept ? decSel : curSel_q;
    arValid_d = arValid_q;
    arAddr_d  = arAddr_q;
    if (accept && !rspAccept) begin
      cnt_d = cnt_q + CW'(1);
    end else if (!accept && rspAccept) begin
      cnt_d = cnt_q - CW'(1);
    end
    for (int i = 0; i < NUM_S; i++) begin
      if (m_axil_arready[i]) begin
        arValid_d[i] = 1'b0;
      end
      if (accept && !decErr && (decSel == SW'(i))) begin
        arValid_d[i] = 1'b1;
        arAddr_d[i]  = decAddr;
      end
    end
  end

  // Router state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      curSel_q  <= '0;
      arValid_q <= '0;
      arAddr_q  <= '0;
    end else begin
      cnt_q     <= cnt_d;
      curSel_q  <= curSel_d;
      arValid_q <= arValid_d;
      arAddr_q  <= arAddr_d;
    end
  end

  assign m_axil_arvalid = arValid_q;
  assign m_axil_araddr  = arAddr_q;

  svc_skidbuf #(
    .WIDTH      (DW + 2),
    .OPT_OUTREG (1'b1)
  ) u_rSkid (
    .clk         (clk),
    .rst         (rst),
    .in_valid_i  (rspValid),
    .in_ready_o  (rspReady),
    .in_data_i   ({rspData, rspResp}),
    .out_valid_o (s_axil_rvalid),
    .out_ready_i (s_axil_rready),
    .out_data_o  (rOutData)
  );

  assign s_axil_rdata = rOutData[DW+1:2];
  assign s_axil_rresp = rOutData[1:0];

`ifdef SVC_AXIL_ROUTER_RD_PIPE_ERRCNT_EN
  logic [15:0] decerrCnt_q;

  // Count unmapped requests as they are accepted, saturating at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      decerrCnt_q <= '0;
    end else if (accept && decErr) begin
      decerrCnt_q <= satInc16(decerrCnt_q);
    end
  end

  assign decerr_count = decerrCnt_q;
`endif

endmodule

// File: tb/tb_svc_axil_router_rd_pipe.sv
// Scoreboard bench for svc_axil_router_rd_pipe.
// Expected responses are computed from the address map when a read is accepted and popped by a
// monitor when the router returns data; subordinate models answer from the address they receive.
module tb_svc_axil_router_rd_pipe;

  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int NUM_S = 2;
  localparam int MAXO  = 4;

  logic                clk = 1'b0;
  logic                rst;
  logic                s_axil_arvalid;
  logic [AW-1:0]       s_axil_araddr;
  logic                s_axil_arready;
  logic                s_axil_rvalid;
  logic [DW-1:0]       s_axil_rdata;
  logic [1:0]          s_axil_rresp;
  logic                s_axil_rready;
  logic [NUM_S-1:0]    m_axil_arvalid;
  logic [NUM_S*AW-1:0] m_axil_araddr;
  logic [NUM_S-1:0]    m_axil_arready;
  logic [NUM_S-1:0]    m_axil_rvalid;
  logic [NUM_S*DW-1:0] m_axil_rdata;
  logic [NUM_S*2-1:0]  m_axil_rresp;
  logic [NUM_S-1:0]    m_axil_rready;
`ifdef SVC_AXIL_ROUTER_RD_PIPE_ERRCNT_EN
  logic [15:0]         decerr_count;
`endif

  int checks   = 0;
  int failures = 0;
  int issued   = 0;
  int dropped  = 0;
  int rspCount = 0;
  int errIssued = 0;

  logic [33:0] expQ [$];

  int          arReadyPct = 100;
  int          latMin = 1;
  int          latMax = 1;
  int          rreadyPct = 100;
  bit          holdRready = 1'b0;
  int          arCount [NUM_S];
  logic [31:0] lastAddr [NUM_S];
  logic [31:0] pendAddr [NUM_S][$];
  int          pendDue  [NUM_S][$];

  always #5 clk = ~clk;

  svc_axil_router_rd_pipe #(
    .AW              (AW),
    .DW              (DW),
    .NUM_S           (NUM_S),
    .S_BASE          ({32'h4000_0000, 32'h0000_0000}),
    .S_MASK          ({32'hC000_0000, 32'hC000_0000}),
    .MAX_OUTSTANDING (MAXO)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .s_axil_arvalid (s_axil_arvalid),
    .s_axil_araddr  (s_axil_araddr),
    .s_axil_arready (s_axil_arready),
    .s_axil_rvalid  (s_axil_rvalid),
    .s_axil_rdata   (s_axil_rdata),
    .s_axil_rresp   (s_axil_rresp),
    .s_axil_rready  (s_axil_rready),
    .m_axil_arvalid (m_axil_arvalid),
    .m_axil_araddr  (m_axil_araddr),
    .m_axil_arready (m_axil_arready),
    .m_axil_rvalid  (m_axil_rvalid),
    .m_axil_rdata   (m_axil_rdata),
    .m_axil_rresp   (m_axil_rresp),
    .m_axil_rready  (m_axil_rready)
`ifdef SVC_AXIL_ROUTER_RD_PIPE_ERRCNT_EN
    ,
    .decerr_count   (decerr_count)
`endif
  );

  // Address map as a reader would state it: top two bits 00 -> sub0, 01 -> sub1, else unmapped.
  function automatic int refTarget(input logic [31:0] a);
    if (a[31:30] == 2'b00) return 0;
    if (a[31:30] == 2'b01) return 1;
    return NUM_S;
  endfunction

  // What subordinate idx returns for a given (already stripped) address.
  function automatic logic [33:0] subResponse(input int idx, input logic [31:0] a);
    logic [31:0] d;
    logic [1:0]  r;
    if (idx == 1 && a == 32'h0000_0010) d = 32'h1234_5678;
    else d = (a * 32'h9E37_79B1) + (32'(idx + 1) * 32'h1000_0001);
    r = a[3] ? 2'b10 : 2'b00;
    return {d, r};
  endfunction

  function automatic logic [33:0] refResponse(input logic [31:0] a);
    int t = refTarget(a);
    if (t == NUM_S) return {32'hADD1EBAD, 2'b11};
    return subResponse(t, {2'b00, a[29:0]});
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Present one read on the manager side; called and returning on a falling edge.
  task automatic applyStimulus(input logic [31:0] addr);
    int  waitCycles = 0;
    bit  done = 1'b0;
    s_axil_arvalid = 1'b1;
    s_axil_araddr  = addr;
    while (!done) begin
      #2;
      if (s_axil_arready) begin
        expQ.push_back(refResponse(addr));
        issued++;
        if (refTarget(addr) == NUM_S) errIssued++;
        done = 1'b1;
      end else if (waitCycles > 300) begin
        checkOutput("ar_accept_timeout", s_axil_arready, 1);
        s_axil_arvalid = 1'b0;
        done = 1'b1;
      end
      waitCycles++;
      @(negedge clk);
    end
  endtask

  task automatic waitDrain();
    int n = 0;
    while (expQ.size() != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (expQ.size() != 0) checkOutput("drain_timeout", expQ.size(), 0);
    @(negedge clk);
  endtask

  // Manager-side monitor: drives rready and scores every returned response in order.
  initial begin
    s_axil_rready = 1'b0;
    forever begin
      @(negedge clk);
      s_axil_rready = holdRready ? 1'b0 : ($urandom_range(99) < rreadyPct);
      #3;
      if (!rst && s_axil_rvalid && s_axil_rready) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpected_response", s_axil_rvalid, 0);
        end else begin
          logic [33:0] e;
          e = expQ.pop_front();
          checkOutput("rdata", s_axil_rdata, e[33:2]);
          checkOutput("rresp", s_axil_rresp, e[1:0]);
          rspCount++;
        end
      end
    end
  end

  // Subordinate models with random arready and per-request latency, answering in order.
  initial begin
    bit          arHs [NUM_S];
    bit          rHs  [NUM_S];
    logic [31:0] arCap [NUM_S];
    int          cycle = 0;
    m_axil_arready = '0;
    m_axil_rvalid  = '0;
    m_axil_rdata   = '0;
    m_axil_rresp   = '0;
    for (int i = 0; i < NUM_S; i++) begin
      arHs[i] = 1'b0; rHs[i] = 1'b0; arCount[i] = 0; lastAddr[i] = '0;
    end
    forever begin
      @(negedge clk);
      cycle++;
      for (int i = 0; i < NUM_S; i++) begin
        if (arHs[i]) begin
          pendAddr[i].push_back(arCap[i]);
          pendDue[i].push_back(cycle + $urandom_range(latMax, latMin));
        end
        if (rHs[i] && pendAddr[i].size() != 0) begin
          void'(pendAddr[i].pop_front());
          void'(pendDue[i].pop_front());
        end
        m_axil_arready[i] = ($urandom_range(99) < arReadyPct);
        if (pendAddr[i].size() != 0 && pendDue[i][0] <= cycle) begin
          logic [33:0] r;
          r = subResponse(i, pendAddr[i][0]);
          m_axil_rvalid[i]          = 1'b1;
          m_axil_rdata[i*DW +: DW]  = r[33:2];
          m_axil_rresp[i*2 +: 2]    = r[1:0];
        end else begin
          m_axil_rvalid[i]          = 1'b0;
          m_axil_rdata[i*DW +: DW]  = '0;
          m_axil_rresp[i*2 +: 2]    = '0;
        end
      end
      #2;
      for (int i = 0; i < NUM_S; i++) begin
        if (rst) begin
          arHs[i] = 1'b0;
          rHs[i]  = 1'b0;
          pendAddr[i].delete();
          pendDue[i].delete();
        end else begin
          arHs[i]  = m_axil_arvalid[i] && m_axil_arready[i];
          rHs[i]   = m_axil_rvalid[i] && m_axil_rready[i];
          arCap[i] = m_axil_araddr[i*AW +: AW];
          if (arHs[i]) begin
            arCount[i]++;
            lastAddr[i] = arCap[i];
            checkOutput("sub_outstanding_le_max", pendAddr[i].size() < MAXO, 1);
            for (int j = 0; j < NUM_S; j++) begin
              if (j != i) checkOutput("switch_waits_for_idle", pendAddr[j].size(), 0);
            end
          end
          for (int j = 0; j < NUM_S; j++) begin
            if (j != i && pendAddr[j].size() != 0) checkOutput("rready_nonselected", m_axil_rready[i], 0);
          end
        end
      end
    end
  end

  // Main sequence of directed scenarios followed by a randomized run.
  initial begin
    int          a0, a1;
    logic [1:0]  region;
    logic [31:0] addr;
    rst            = 1'b1;
    s_axil_arvalid = 1'b0;
    s_axil_araddr  = '0;

    repeat (3) @(negedge clk);
    #2;
    checkOutput("reset_m_arvalid", m_axil_arvalid, 0);
    checkOutput("reset_s_rvalid", s_axil_rvalid, 0);
    checkOutput("reset_m_rready", m_axil_rready, 0);
    @(negedge clk);
    rst = 1'b0;
    #2;
    checkOutput("reset_arready", s_axil_arready, 1);
`ifdef SVC_AXIL_ROUTER_RD_PIPE_ERRCNT_EN
    checkOutput("reset_decerr_count", decerr_count, 0);
`endif
    @(negedge clk);

    // Single read to sub1 with address stripping.
    a0 = arCount[0]; a1 = arCount[1];
    applyStimulus(32'h4000_0010);
    s_axil_arvalid = 1'b0;
    waitDrain();
    checkOutput("t1_sub0_untouched", arCount[0], a0);
    checkOutput("t1_sub1_one_ar", arCount[1], a1 + 1);
    checkOutput("t1_stripped_addr", lastAddr[1], 32'h0000_0010);

    // Six back-to-back reads to sub0 with a fixed three-cycle latency.
    latMin = 3; latMax = 3;
    a0 = arCount[0];
    for (int k = 0; k < 6; k++) applyStimulus(32'h0000_0100 + 32'(k * 4));
    s_axil_arvalid = 1'b0;
    waitDrain();
    checkOutput("t2_sub0_ar_count", arCount[0], a0 + 6);

    // Target switch right after a read to the other subordinate.
    applyStimulus(32'h0000_0020);
    applyStimulus(32'h4000_0020);
    s_axil_arvalid = 1'b0;
    waitDrain();

    // Unmapped reads: no downstream traffic, DECERR data.
    a0 = arCount[0]; a1 = arCount[1];
    applyStimulus(32'h8000_0000);
    s_axil_arvalid = 1'b0;
    waitDrain();
    checkOutput("t4_no_sub_traffic", arCount[0] + arCount[1], a0 + a1);
`ifdef SVC_AXIL_ROUTER_RD_PIPE_ERRCNT_EN
    checkOutput("t4_decerr_count", decerr_count, 1);
`endif

    // Manager stalls rready for ten cycles with four reads in flight.
    latMin = 1; latMax = 1;
    holdRready = 1'b1;
    for (int k = 0; k < 4; k++) applyStimulus(32'h4000_0200 + 32'(k * 8));
    s_axil_arvalid = 1'b0;
    repeat (10) @(negedge clk);
    #2;
    checkOutput("t5_m_rready_backpressure", m_axil_rready, 0);
    checkOutput("t5_s_rvalid_held", s_axil_rvalid, 1);
    @(negedge clk);
    holdRready = 1'b0;
    waitDrain();

    // Reset with three reads outstanding.
    latMin = 30; latMax = 30;
    for (int k = 0; k < 3; k++) applyStimulus(32'h0000_0300 + 32'(k * 4));
    s_axil_arvalid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #2;
    checkOutput("t6_rst_m_arvalid", m_axil_arvalid, 0);
    checkOutput("t6_rst_s_rvalid", s_axil_rvalid, 0);
    checkOutput("t6_rst_m_rready", m_axil_rready, 0);
    checkOutput("t6_rst_arready", s_axil_arready, 1);
    dropped += expQ.size();
    expQ.delete();
    @(negedge clk);
    rst = 1'b0;
    latMin = 0; latMax = 4;
    @(negedge clk);
    applyStimulus(32'h4000_0040);
    s_axil_arvalid = 1'b0;
    waitDrain();

    // Randomized traffic across all regions with random back-pressure on both sides.
    arReadyPct = 70;
    rreadyPct  = 75;
    for (int k = 0; k < 200; k++) begin
      region = 2'($urandom_range(3));
      addr   = {region, 30'($urandom)};
      applyStimulus(addr);
      if ($urandom_range(3) == 0) begin
        s_axil_arvalid = 1'b0;
        @(negedge clk);
      end
    end
    s_axil_arvalid = 1'b0;
    waitDrain();

    checkOutput("final_response_count", rspCount, issued - dropped);
`ifdef SVC_AXIL_ROUTER_RD_PIPE_ERRCNT_EN
    checkOutput("final_decerr_count", decerr_count, errIssued);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Watchdog so the run always ends with a summary.
  initial begin
    #600000;
    $display("[TB] FAIL watchdog actual=running required=finished");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
